// File: rtl/l1_bank_arb_pkg.sv
// Shared types and helpers for the L1 bank arbiter.
// Default payload widths match the standard 32-bit TCDM channel.
package l1_bank_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned ID_W   = 1;

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] add;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
    logic [ID_W-1:0]   id;
  } l1_req_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/l1_rr_picker.sv
// Combinational rotating-priority picker: first set request at or after start, modulo N.
module l1_rr_picker #(
  parameter  int unsigned N    = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] start,
  output logic [IdxW-1:0] winner,
  output logic            valid
);

  logic [IdxW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IdxW'((32'(start) + k) % N);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/l1_bank_arbiter.sv
// Round-robin arbiter merging N_MST TCDM initiators onto one L1 SPM bank port.
// Optional conflict counter enabled with macro L1_BANK_ARB_PERF_EN.
module l1_bank_arbiter #(
  parameter  int unsigned N_MST  = 4,
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned ID_W   = 1,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_MST-1:0]        mst_req_i,
  output logic [N_MST-1:0]        mst_gnt_o,
  input  logic [N_MST-1:0]        mst_wen_i,
  input  logic [N_MST*ADDR_W-1:0] mst_add_i,
  input  logic [N_MST*DATA_W-1:0] mst_data_i,
  input  logic [N_MST*BE_W-1:0]   mst_be_i,
  input  logic [N_MST*ID_W-1:0]   mst_id_i,
  output logic [N_MST-1:0]        mst_r_valid_o,
  output logic [N_MST*DATA_W-1:0] mst_r_data_o,
  output logic [N_MST*ID_W-1:0]   mst_r_id_o,
  output logic                    bank_req_o,
  input  logic                    bank_gnt_i,
  output logic                    bank_wen_o,
  output logic [ADDR_W-1:0]       bank_add_o,
  output logic [DATA_W-1:0]       bank_data_o,
  output logic [BE_W-1:0]         bank_be_o,
  output logic [ID_W-1:0]         bank_id_o,
`ifdef L1_BANK_ARB_PERF_EN
  input  logic                    perf_clr_i,
  output logic [CNT_W-1:0]        perf_conflict_cnt_o,
`endif
  input  logic [DATA_W-1:0]       bank_r_data_i,
  input  logic [ID_W-1:0]         bank_r_id_i
);

  import l1_bank_arb_pkg::*;

  localparam int unsigned IDX_W = $clog2(N_MST);

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] add;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
    logic [ID_W-1:0]   id;
  } payload_t;

  payload_t         mst_pl [N_MST];
  payload_t         sel_pl;
  logic [IDX_W-1:0] rr_q, rr_d, winner, resp_sel_q;
  logic             any_req, accept, resp_vld_q;

  l1_rr_picker #(
    .N (N_MST)
  ) u_picker (
    .req    (mst_req_i),
    .start  (rr_q),
    .winner (winner),
    .valid  (any_req)
  );

  always_comb begin
    for (int unsigned i = 0; i < N_MST; i++) begin
      mst_pl[i] = '{wen:  mst_wen_i[i],
                    add:  mst_add_i[i*ADDR_W +: ADDR_W],
                    data: mst_data_i[i*DATA_W +: DATA_W],
                    be:   mst_be_i[i*BE_W +: BE_W],
                    id:   mst_id_i[i*ID_W +: ID_W]};
    end
  end

  assign sel_pl      = any_req ? mst_pl[winner] : '0;
  assign bank_req_o  = any_req;
  assign bank_wen_o  = sel_pl.wen;
  assign bank_add_o  = sel_pl.add;
  assign bank_data_o = sel_pl.data;
  assign bank_be_o   = sel_pl.be;
  assign bank_id_o   = sel_pl.id;

  assign accept = any_req & bank_gnt_i;
  assign rr_d   = accept ? IDX_W'(rr_next(32'(winner), N_MST)) : rr_q;

  // Grant and response steering; the bank's read data is only valid in the response cycle.
  always_comb begin
    mst_gnt_o     = '0;
    mst_r_valid_o = '0;
    mst_r_data_o  = '0;
    if (any_req) mst_gnt_o[winner] = bank_gnt_i;
    if (resp_vld_q) begin
      mst_r_valid_o[resp_sel_q]                  = 1'b1;
      mst_r_data_o[resp_sel_q*DATA_W +: DATA_W] = bank_r_data_i;
    end
  end

  assign mst_r_id_o = {N_MST{bank_r_id_i}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      resp_vld_q <= 1'b0;
      resp_sel_q <= '0;
    end else begin
      rr_q       <= rr_d;
      resp_vld_q <= accept;
      resp_sel_q <= winner;
    end
  end

`ifdef L1_BANK_ARB_PERF_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             conflict;

  assign conflict = $countones(mst_req_i) > 1;

  always_comb begin
    cnt_d = cnt_q;
    if (perf_clr_i)                 cnt_d = '0;
    else if (conflict && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign perf_conflict_cnt_o = cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule
